// File: rtl/branch_predictor.sv
// branch_predictor: IF-stage next-PC predictor for the 16-bit TSC core.
// Direct-mapped BTB with 2-bit saturating counters, an ID-stage copy of the
// prediction that travels with the IR, and the ID-stage miss check and
// training path.
// Optional build macro BP_STATS_EN adds num_ctrl / num_miss statistics outputs.
module branch_predictor #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_if,
    output logic [WORD_SIZE-1:0] next_pc_pred,
    output logic                 taken_pred_if,
    input  logic                 ir_write,
    input  logic                 flush_if,
    input  logic                 resolve_valid,
    input  logic                 resolve_is_ctrl,
    input  logic                 resolve_taken,
    input  logic [WORD_SIZE-1:0] resolve_target,
    output logic                 branch_miss,
    output logic [WORD_SIZE-1:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [15:0]          num_ctrl,
    output logic [15:0]          num_miss
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;

    // BTB storage
    logic                 valid_q  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    // ID-stage copy of the IF prediction
    logic                 id_valid_q,       id_valid_d;
    logic [WORD_SIZE-1:0] pc_id_q,          pc_id_d;
    logic                 pred_taken_id_q,  pred_taken_id_d;
    logic [WORD_SIZE-1:0] pred_target_id_q, pred_target_id_d;

    // IF lookup signals
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;

    // ID resolution / training signals
    logic                  actual_taken;
    logic                  check_en;
    logic                  train_en;
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_W-1:0]      id_tag;
    logic                  id_hit;

    // Single-entry BTB write produced by training
    logic                  upd_en;
    logic                  upd_valid_d;
    logic [TAG_W-1:0]      upd_tag_d;
    logic [WORD_SIZE-1:0]  upd_target_d;
    logic [1:0]            upd_ctr_d;

    // Lookup the fetch PC; the pre-update entry is seen even if it is trained this cycle
    always_comb begin
        if_idx        = pc_if[INDEX_BITS-1:0];
        if_tag        = pc_if[WORD_SIZE-1:INDEX_BITS];
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        taken_pred_if = if_hit && ctr_q[if_idx][1];
        next_pc_pred  = taken_pred_if ? target_q[if_idx] : pc_if + WORD_SIZE'(1);
    end

    // ID-stage next state: flush wins over ir_write, otherwise hold on stall
    always_comb begin
        id_valid_d       = id_valid_q;
        pc_id_d          = pc_id_q;
        pred_taken_id_d  = pred_taken_id_q;
        pred_target_id_d = pred_target_id_q;
        if (flush_if) begin
            id_valid_d = 1'b0;
        end else if (ir_write) begin
            id_valid_d       = 1'b1;
            pc_id_d          = pc_if;
            pred_taken_id_d  = taken_pred_if;
            pred_target_id_d = next_pc_pred;
        end
    end

    // ID-stage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_q       <= 1'b0;
            pc_id_q          <= '0;
            pred_taken_id_q  <= 1'b0;
            pred_target_id_q <= '0;
        end else begin
            id_valid_q       <= id_valid_d;
            pc_id_q          <= pc_id_d;
            pred_taken_id_q  <= pred_taken_id_d;
            pred_target_id_q <= pred_target_id_d;
        end
    end

    // Compare the carried prediction with the resolved outcome
    always_comb begin
        actual_taken = resolve_is_ctrl && resolve_taken;
        check_en     = id_valid_q && resolve_valid;
        branch_miss  = 1'b0;
        if (check_en) begin
            if (pred_taken_id_q != actual_taken) begin
                branch_miss = 1'b1;
            end else if (actual_taken && (pred_target_id_q != resolve_target)) begin
                branch_miss = 1'b1;
            end
        end
        correct_pc = actual_taken ? resolve_target : pc_id_q + WORD_SIZE'(1);
    end

    // Training decision; ir_write gating makes a stalled instruction train once
    always_comb begin
        train_en     = check_en && ir_write;
        id_idx       = pc_id_q[INDEX_BITS-1:0];
        id_tag       = pc_id_q[WORD_SIZE-1:INDEX_BITS];
        id_hit       = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        upd_en       = 1'b0;
        upd_valid_d  = valid_q[id_idx];
        upd_tag_d    = tag_q[id_idx];
        upd_target_d = target_q[id_idx];
        upd_ctr_d    = ctr_q[id_idx];
        if (train_en) begin
            if (resolve_is_ctrl) begin
                if (id_hit) begin
                    upd_en = 1'b1;
                    if (resolve_taken) begin
                        upd_ctr_d    = (ctr_q[id_idx] == 2'b11) ? 2'b11 : ctr_q[id_idx] + 2'd1;
                        upd_target_d = resolve_target;
                    end else begin
                        upd_ctr_d    = (ctr_q[id_idx] == 2'b00) ? 2'b00 : ctr_q[id_idx] - 2'd1;
                    end
                end else if (resolve_taken) begin
                    upd_en       = 1'b1;
                    upd_valid_d  = 1'b1;
                    upd_tag_d    = id_tag;
                    upd_target_d = resolve_target;
                    upd_ctr_d    = 2'b10;
                end
            end else if (id_hit) begin
                // Non-control instruction aliasing onto a BTB entry: drop it
                upd_en      = 1'b1;
                upd_valid_d = 1'b0;
            end
        end
    end

    // BTB storage update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[id_idx]  <= upd_valid_d;
            tag_q[id_idx]    <= upd_tag_d;
            target_q[id_idx] <= upd_target_d;
            ctr_q[id_idx]    <= upd_ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] num_ctrl_q;
    logic [15:0] num_miss_q;

    // Saturating counts of trained control instructions and trained misses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_ctrl_q <= '0;
            num_miss_q <= '0;
        end else begin
            if (train_en && resolve_is_ctrl && (num_ctrl_q != 16'hFFFF)) begin
                num_ctrl_q <= num_ctrl_q + 16'd1;
            end
            if (train_en && branch_miss && (num_miss_q != 16'hFFFF)) begin
                num_miss_q <= num_miss_q + 16'd1;
            end
        end
    end

    assign num_ctrl = num_ctrl_q;
    assign num_miss = num_miss_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, a reset-mid-run
// sequence, then randomized traffic checked against a behavioural BTB model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_if;
    logic [15:0] next_pc_pred;
    logic        taken_pred_if;
    logic        ir_write;
    logic        flush_if;
    logic        resolve_valid;
    logic        resolve_is_ctrl;
    logic        resolve_taken;
    logic [15:0] resolve_target;
    logic        branch_miss;
    logic [15:0] correct_pc;
`ifdef BP_STATS_EN
    logic [15:0] num_ctrl;
    logic [15:0] num_miss;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk             (clk),
        .reset           (reset),
        .pc_if           (pc_if),
        .next_pc_pred    (next_pc_pred),
        .taken_pred_if   (taken_pred_if),
        .ir_write        (ir_write),
        .flush_if        (flush_if),
        .resolve_valid   (resolve_valid),
        .resolve_is_ctrl (resolve_is_ctrl),
        .resolve_taken   (resolve_taken),
        .resolve_target  (resolve_target),
        .branch_miss     (branch_miss),
        .correct_pc      (correct_pc)
`ifdef BP_STATS_EN
        ,
        .num_ctrl        (num_ctrl),
        .num_miss        (num_miss)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] pc, input logic irw, input logic fl, input logic rv,
                         input logic ctrl, input logic tk, input logic [15:0] tgt);
        pc_if           = pc;
        ir_write        = irw;
        flush_if        = fl;
        resolve_valid   = rv;
        resolve_is_ctrl = ctrl;
        resolve_taken   = tk;
        resolve_target  = tgt;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic        irw, fl, rv, ctrl, tk;
        logic [15:0] tgt;
        logic        e_tp;
        logic [15:0] e_npc;
        logic        e_miss;
        logic        chk_cpc;
        logic [15:0] e_cpc;
    } vec_t;

    vec_t vecs[20];

    // Behavioural model: BTB as per-slot records keyed by full branch PC
    logic        m_valid [16];
    logic [15:0] m_pc    [16];
    logic [15:0] m_tgt   [16];
    int          m_str   [16];
    logic        m_idv;
    logic [15:0] m_idpc;
    logic        m_idpt;
    logic [15:0] m_idnext;
    int          m_nctrl, m_nmiss;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_str[i]   = 1;
        end
        m_idv    = 1'b0;
        m_idpc   = '0;
        m_idpt   = 1'b0;
        m_idnext = '0;
        m_nctrl  = 0;
        m_nmiss  = 0;
    endtask

    initial begin
        // ---------------- reset ----------------
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        vecs[0]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b1, 16'h0001};
        vecs[1]  = '{16'h0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0012, 1'b1, 1'b1, 16'h0040};
        vecs[2]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{16'h0040, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0041, 1'b1, 1'b1, 16'h0011};
        vecs[4]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{16'h0011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0012, 1'b0, 1'b1, 16'h0011};
        vecs[6]  = '{16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b1, 16'h0012};
        vecs[7]  = '{16'h0011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0012, 1'b1, 1'b1, 16'h0040};
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = '{16'h0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0012, 1'b1, 1'b1, 16'h0040};
        vecs[11] = '{16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000};
        vecs[12] = '{16'h0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0012, 1'b1, 1'b1, 16'h0040};
        vecs[13] = '{16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040};
        vecs[14] = '{16'h0020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0021, 1'b0, 1'b1, 16'h0040};
        vecs[15] = '{16'h0021, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0022, 1'b0, 1'b1, 16'h0021};
        vecs[16] = '{16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0022};
        vecs[17] = '{16'h0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0041, 1'b1, 1'b1, 16'h0011};
        vecs[18] = '{16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000};
        vecs[19] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].irw, vecs[i].fl, vecs[i].rv, vecs[i].ctrl, vecs[i].tk, vecs[i].tgt);
            #1;
            check($sformatf("vec%0d taken_pred_if", i), {15'd0, taken_pred_if}, {15'd0, vecs[i].e_tp});
            check($sformatf("vec%0d next_pc_pred", i), next_pc_pred, vecs[i].e_npc);
            check($sformatf("vec%0d branch_miss", i), {15'd0, branch_miss}, {15'd0, vecs[i].e_miss});
            if (vecs[i].chk_cpc) begin
                check($sformatf("vec%0d correct_pc", i), correct_pc, vecs[i].e_cpc);
            end
        end

        // ---------------- reset in the middle of operation ----------------
        @(negedge clk);
        drive(16'h0030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        drive(16'h0031, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0050);
        #1;
        check("mid alloc branch_miss", {15'd0, branch_miss}, 16'd1);
        @(negedge clk);
        drive(16'h0030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        check("mid trained taken_pred_if", {15'd0, taken_pred_if}, 16'd1);
        check("mid trained next_pc_pred", next_pc_pred, 16'h0050);
        reset = 1'b1;
        resolve_valid = 1'b1;
        resolve_is_ctrl = 1'b1;
        resolve_taken = 1'b0;
        #1;
        check("reset taken_pred_if", {15'd0, taken_pred_if}, 16'd0);
        check("reset next_pc_pred", next_pc_pred, 16'h0031);
        check("reset branch_miss", {15'd0, branch_miss}, 16'd0);
        check("reset correct_pc", correct_pc, 16'h0001);
`ifdef BP_STATS_EN
        check("reset num_ctrl", num_ctrl, 16'd0);
        check("reset num_miss", num_miss, 16'd0);
`endif
        repeat (2) @(negedge clk);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        model_reset();

        // ---------------- randomized traffic vs model ----------------
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [15:0] pc, tgt, e_npc, e_cpc;
            logic        irw, fl, rv, ctrl, tk, hit, e_tp, act, chk, e_miss;
            int          idx, tidx;

            @(negedge clk);
            pc   = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                               : 16'($urandom_range(0, 47));
            tgt  = 16'($urandom_range(0, 7) * 16 + $urandom_range(0, 1));
            irw  = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 4) == 0);
            rv   = ($urandom_range(0, 3) != 0);
            ctrl = $urandom_range(0, 1) == 1;
            tk   = $urandom_range(0, 1) == 1;
            drive(pc, irw, fl, rv, ctrl, tk, tgt);

            idx    = int'(pc % 16);
            hit    = m_valid[idx] && (m_pc[idx] == pc);
            e_tp   = hit && (m_str[idx] >= 2);
            e_npc  = e_tp ? m_tgt[idx] : pc + 16'd1;
            act    = ctrl && tk;
            chk    = m_idv && rv;
            e_miss = chk && ((m_idpt != act) || (act && (m_idnext != tgt)));
            e_cpc  = act ? tgt : m_idpc + 16'd1;

            #1;
            check("rnd taken_pred_if", {15'd0, taken_pred_if}, {15'd0, e_tp});
            check("rnd next_pc_pred", next_pc_pred, e_npc);
            check("rnd branch_miss", {15'd0, branch_miss}, {15'd0, e_miss});
            if (m_idv || act) begin
                check("rnd correct_pc", correct_pc, e_cpc);
            end
`ifdef BP_STATS_EN
            check("rnd num_ctrl", num_ctrl, 16'(m_nctrl));
            check("rnd num_miss", num_miss, 16'(m_nmiss));
`endif

            @(posedge clk);
            if (chk && irw) begin
                tidx = int'(m_idpc % 16);
                if (ctrl && m_nctrl < 65535) m_nctrl++;
                if (e_miss && m_nmiss < 65535) m_nmiss++;
                if (ctrl) begin
                    if (m_valid[tidx] && m_pc[tidx] == m_idpc) begin
                        if (tk) begin
                            if (m_str[tidx] < 3) m_str[tidx]++;
                            m_tgt[tidx] = tgt;
                        end else if (m_str[tidx] > 0) begin
                            m_str[tidx]--;
                        end
                    end else if (tk) begin
                        m_valid[tidx] = 1'b1;
                        m_pc[tidx]    = m_idpc;
                        m_tgt[tidx]   = tgt;
                        m_str[tidx]   = 2;
                    end
                end else if (m_valid[tidx] && m_pc[tidx] == m_idpc) begin
                    m_valid[tidx] = 1'b0;
                end
            end
            if (fl) begin
                m_idv = 1'b0;
            end else if (irw) begin
                m_idv    = 1'b1;
                m_idpc   = pc;
                m_idpt   = e_tp;
                m_idnext = e_npc;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
